// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store initiator in front of a word-only data memory.
// Sub-word stores are performed as read-modify-write, and sub-word loads
// are extracted from the addressed lane and sign/zero extended.
module lsu_rmw #(
    parameter int unsigned ADDR_LIMIT = 256
) (
    input  logic        iwClk,
    input  logic        iwnRst,
    input  logic        iwReq,
    input  logic        iwWe,
    input  logic [1:0]  iwSize,
    input  logic        iwSigned,
    input  logic [31:0] iwAddr,
    input  logic [31:0] iwWdata,
    output logic        owReady,
    output logic        owDone,
    output logic        owFault,
    output logic [31:0] owRdata,
    output logic [31:0] owMemReadAddr,
    output logic [31:0] owMemWriteAddr,
    output logic [31:0] owMemWriteData,
    output logic [3:0]  owMemWstrb,
    input  logic [31:0] iwMemReadData
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        fault_q;
    logic [31:0] merged_q;
    logic [31:0] rdata_q;
    logic        req_fault;
    logic        accept;

    // Pick the addressed byte/half out of a word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = {{24{sgn & b[7]}}, b};
            2'b01:   res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed byte/half of a word with right-justified store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wd,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] res;
        res = word;
        case (size)
            2'b00: res[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lane[1]) res[31:16] = wd[15:0];
                else         res[15:0]  = wd[15:0];
            end
            default: res = wd;
        endcase
        return res;
    endfunction

    assign accept = (state == IDLE) && iwReq;

    // Classify the incoming request: illegal size, misalignment or out of range.
    always_comb begin
        req_fault = 1'b0;
        if (iwSize == 2'b11)                           req_fault = 1'b1;
        if ((iwSize == 2'b01) && iwAddr[0])            req_fault = 1'b1;
        if ((iwSize == 2'b10) && (iwAddr[1:0] != 2'b00)) req_fault = 1'b1;
        if (iwAddr >= 32'(ADDR_LIMIT))                 req_fault = 1'b1;
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) state <= IDLE;
        else         state <= state_nxt;
    end

    // Capture the request at acceptance so inputs may change afterwards.
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else if (accept) begin
            we_q    <= iwWe;
            size_q  <= iwSize;
            sign_q  <= iwSigned;
            addr_q  <= iwAddr;
            wdata_q <= iwWdata;
            fault_q <= req_fault;
        end
    end

    // Load result and merged store word, each latched in its own state.
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            rdata_q  <= 32'h0;
            merged_q <= 32'h0;
        end else begin
            if (state == LOAD)
                rdata_q <= load_extract(iwMemReadData, size_q, addr_q[1:0], sign_q);
            if (state == RMW_RD)
                merged_q <= store_merge(iwMemReadData, wdata_q, size_q, addr_q[1:0]);
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (iwReq) begin
                    if (req_fault)            state_nxt = DONE;
                    else if (!iwWe)           state_nxt = LOAD;
                    else if (iwSize == 2'b10) state_nxt = WRITE;
                    else                      state_nxt = RMW_RD;
                end
            end
            LOAD:    state_nxt = DONE;
            RMW_RD:  state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and memory-port outputs decoded from the current state.
    always_comb begin
        owReady        = (state == IDLE);
        owDone         = (state == DONE);
        owFault        = (state == DONE) && fault_q;
        owRdata        = rdata_q;
        owMemReadAddr  = {addr_q[31:2], 2'b00};
        owMemWriteAddr = 32'h0;
        owMemWriteData = 32'h0;
        owMemWstrb     = 4'b0000;
        if (state == WRITE) begin
            owMemWstrb     = 4'b1111;
            owMemWriteAddr = {addr_q[31:2], 2'b00};
            owMemWriteData = (size_q == 2'b10) ? wdata_q : merged_q;
        end
    end

    logic unused_we;
    assign unused_we = we_q;

endmodule
